ctrl_program_loader: RTL and testbench
======================================

Name: ctrl_program_loader

Overview:
- Host-side initiator for the LUD control-store tester. Takes a stream of CTRL_WIDTH control words from the PS/host and writes them sequentially into the control BRAM through the tester's Zynq BRAM port.
- Once loaded, it drives START and tracks the tester's COMPLETED handshake. It measures execution cycles and reports status.
- Sits between the host interface logic and the tester; it is the only driver of START and of the Zynq BRAM port.

Parameters:
- ADDR_WIDTH, 10, control BRAM address width; capacity 2^ADDR_WIDTH words.
- CTRL_WIDTH, 60, control word width.
- CNT_WIDTH, 32, width of the execution cycle counter.
- ARM_TIMEOUT, 1024, maximum cycles to wait for COMPLETED to fall after START rises.

Ports:
- CLK_100 in 1: system clock; all logic on rising edge.
- RST in 1: asynchronous, active-high reset.
- cmd_load in 1: single-cycle pulse; begin a program load at address 0.
- cmd_run in 1: single-cycle pulse; start execution of the loaded program.
- cmd_clear in 1: single-cycle pulse; drop START, clear status, return to IDLE.
- s_valid in 1: stream word valid.
- s_ready out 1: loader accepts the word this cycle.
- s_data in CTRL_WIDTH: control word.
- s_last in 1: marks the final word of the program.
- bram_addr out ADDR_WIDTH: to tester bram_ZYNQ_INST_addr.
- bram_din out CTRL_WIDTH: to tester bram_ZYNQ_INST_din.
- bram_en out 1: to tester bram_ZYNQ_INST_en.
- bram_we out 1: to tester bram_ZYNQ_INST_we.
- START out 1: to tester START.
- COMPLETED in 1: from tester; 1 when idle or done, 0 while running.
- busy out 1: state is LOAD, ARM or RUN.
- done out 1: state is DONE.
- error out 2: 00 none, 01 overflow, 10 arm timeout, 11 run without program.
- word_count out ADDR_WIDTH+1: number of words written in the last load.
- cycle_count out CNT_WIDTH: cycles spent in RUN, saturating.

Behaviour:
- Reset: state IDLE. All outputs 0: s_ready, bram_*, START, busy, done, error, word_count, cycle_count.
- States: IDLE, LOAD, ARM, RUN, DONE, ERR.
- START is registered. It is 1 only in ARM, RUN and DONE, so the BRAM port is only ever driven while START=0, when the tester muxes that port to this block.
- IDLE
  - On cmd_load: go to LOAD; clear the address and word_count; clear error.
  - On cmd_run with word_count==0: go to ERR with error=11.
  - On cmd_run with word_count>0: go to ARM and clear cycle_count.
  - If cmd_load and cmd_run occur together, cmd_load wins.
- LOAD
  - s_ready=1.
  - On a handshake (s_valid & s_ready), in the same cycle: bram_en=1, bram_we=1, bram_addr=current address, bram_din=s_data. These are combinational from the handshake, for single-cycle BRAM write timing.
  - After the handshake, the address increments and word_count increments.
  - A handshake with s_last: go to IDLE. word_count holds the final length, up to and including 2^ADDR_WIDTH.
  - A handshake at address 2^ADDR_WIDTH-1 without s_last: the word is written, then go to ERR with error=01 and s_ready=0. The address does not wrap.
  - cmd_run is ignored in LOAD.
- ARM
  - Timer counts from 0.
  - COMPLETED==0: go to RUN; cycle_count=1 in that cycle.
  - Timer reaches ARM_TIMEOUT-1 with COMPLETED still 1: go to ERR with error=10.
- RUN
  - cycle_count increments each cycle and saturates at all-ones; no wrap.
  - COMPLETED==1: go to DONE; that cycle is not counted.
- DONE: done=1, START stays 1 so the tester holds its done state; wait for cmd_clear.
- ERR: START=0, s_ready=0; error holds; wait for cmd_clear.
- cmd_clear, from any state except LOAD:
  - Next cycle state is IDLE and START=0.
  - done, error and cycle_count are cleared; word_count is kept.
  - In LOAD, cmd_clear aborts the load: go to IDLE with word_count=0.
- Precedence: cmd_clear has priority over all other events in the same cycle.
- Asserting RST in any state, mid-load or mid-run, asynchronously forces START=0 and all outputs to their reset values.

Decomposition:
- Shared package ctrl_loader_pkg contains:
  - state encoding (6 localparams, 3 bits);
  - error codes NONE, OVERFLOW, ARM_TO, NO_PROG;
  - bit positions of the control word's complete bit (bit 0).
- One sub-module, sat_counter (parameter WIDTH; clear, enable, saturating increment, async active-high reset). It is instantiated for cycle_count and for the ARM timer.
- The address register reuses the existing myReg.

Test Plan:
- Load 4 words (s_last on the 4th), with s_valid gapped every other cycle → exactly 4 writes at addresses 0..3 with matching din; word_count=4; state IDLE; START stays 0 throughout.
- After that load, cmd_run; tester model drops COMPLETED 2 cycles after START and raises it 10 cycles later → START=1, cycle_count=10, done=1. cmd_clear → START=0 next cycle, done=0.
- ADDR_WIDTH=3, stream 9 words with no s_last → 8 writes at addresses 0..7; error=01; s_ready=0; 9th word not accepted; no write to address 0.
- cmd_run with COMPLETED held at 1 and ARM_TIMEOUT=16 → error=10 after 16 cycles; START=0.
- cmd_run right after reset (word_count=0) → error=11; START never rises.
- RST asserted during RUN after 5 counted cycles → START, busy and cycle_count read 0 before the next clock edge.

Source files
------------

// File: rtl/ctrl_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_loader_pkg
//  Description : Shared definitions for the control-store program loader:
//                FSM state encoding, error codes and control-word bit fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_loader_pkg;

    // FSM state encoding (3 bits, 6 states used)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ARM  = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_ARM  = ST_ARM,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE,
        S_ERR  = ST_ERR
    } state_t;

    // Error codes reported on the error output
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW = 2'b01;
    localparam logic [1:0] ERR_ARM_TO   = 2'b10;
    localparam logic [1:0] ERR_NO_PROG  = 2'b11;

    // Position of the "complete" bit inside a control word
    localparam int CTRL_COMPLETE_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/myReg.sv
`default_nettype none
// ============================================================================
//  Module      : myReg
//  Description : Generic load-enable register with asynchronous reset.
//  Ports       : clk, rst (async, active-high), en_i (load), d_i, q_o
//  Revision    : 1.0 - initial release
// ============================================================================
module myReg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter with synchronous clear, count enable and
//                saturation at all-ones. Clear has priority over enable.
//  Ports       : clk, rst (async, active-high), clear_i, en_i, count_o
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ctrl_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_program_loader
//  Description : Host-side initiator for the control-store tester. Streams a
//                program into the control BRAM through the tester's Zynq port,
//                then drives START, follows the COMPLETED handshake, counts
//                execution cycles and reports status.
//  Ports       : CLK_100, RST (async, active-high)
//                cmd_load/cmd_run/cmd_clear  host command pulses
//                s_valid/s_ready/s_data/s_last  program word stream
//                bram_addr/bram_din/bram_en/bram_we  tester BRAM write port
//                START/COMPLETED  tester handshake
//                busy/done/error/word_count/cycle_count  status
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_program_loader
    import ctrl_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int CTRL_WIDTH  = 60,
    parameter int CNT_WIDTH   = 32,
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic                  CLK_100,
    input  logic                  RST,
    input  logic                  cmd_load,
    input  logic                  cmd_run,
    input  logic                  cmd_clear,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CTRL_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [CTRL_WIDTH-1:0] bram_din,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic                  START,
    input  logic                  COMPLETED,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            error,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    // Timer is one bit wider than needed so ARM_TIMEOUT-1 always fits
    localparam int C_TMR_W = $clog2(ARM_TIMEOUT) + 1;

    state_t                  state_q, state_d;
    logic                    start_q, start_d;
    logic [1:0]              error_q, error_d;
    logic [ADDR_WIDTH:0]     wc_q, wc_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [C_TMR_W-1:0]      w_timer;
    logic                    w_hs;
    logic                    w_addr_max;
    logic                    w_load_start;
    logic                    w_cyc_clear;
    logic                    w_cyc_en;

    assign w_hs       = (state_q == S_LOAD) && s_valid;
    assign w_addr_max = &addr_q;

    // Write address: zeroed when a load begins, then advances per accepted
    // word. It holds at the top address instead of wrapping.
    myReg #(.WIDTH(ADDR_WIDTH)) u_addr_reg (
        .clk  (CLK_100),
        .rst  (RST),
        .en_i (w_load_start || (w_hs && !w_addr_max)),
        .d_i  (w_load_start ? '0 : addr_q + ADDR_WIDTH'(1)),
        .q_o  (addr_q)
    );

    // Cycles with COMPLETED low while armed or running are execution cycles;
    // this includes the ARM cycle that sees COMPLETED fall.
    assign w_cyc_en = ((state_q == S_ARM) || (state_q == S_RUN)) && !COMPLETED;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk     (CLK_100),
        .rst     (RST),
        .clear_i (w_cyc_clear),
        .en_i    (w_cyc_en),
        .count_o (cycle_count)
    );

    sat_counter #(.WIDTH(C_TMR_W)) u_arm_timer (
        .clk     (CLK_100),
        .rst     (RST),
        .clear_i (state_q != S_ARM),
        .en_i    (state_q == S_ARM),
        .count_o (w_timer)
    );

    always_comb begin
        state_d      = state_q;
        error_d      = error_q;
        wc_d         = wc_q;
        w_load_start = 1'b0;
        w_cyc_clear  = 1'b0;

        if (cmd_clear) begin
            state_d     = S_IDLE;
            error_d     = ERR_NONE;
            w_cyc_clear = 1'b1;
            if (state_q == S_LOAD) begin
                wc_d = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_load) begin
                        state_d      = S_LOAD;
                        wc_d         = '0;
                        error_d      = ERR_NONE;
                        w_load_start = 1'b1;
                    end else if (cmd_run) begin
                        if (wc_q == '0) begin
                            state_d = S_ERR;
                            error_d = ERR_NO_PROG;
                        end else begin
                            state_d     = S_ARM;
                            w_cyc_clear = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        wc_d = wc_q + (ADDR_WIDTH+1)'(1);
                        if (s_last) begin
                            state_d = S_IDLE;
                        end else if (w_addr_max) begin
                            state_d = S_ERR;
                            error_d = ERR_OVERFLOW;
                        end
                    end
                end
                S_ARM: begin
                    if (!COMPLETED) begin
                        state_d = S_RUN;
                    end else if (w_timer == C_TMR_W'(ARM_TIMEOUT - 1)) begin
                        state_d = S_ERR;
                        error_d = ERR_ARM_TO;
                    end
                end
                S_RUN: begin
                    if (COMPLETED) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE, S_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        start_d = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DONE);
    end

    always_ff @(posedge CLK_100 or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            error_q <= ERR_NONE;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            error_q <= error_d;
            wc_q    <= wc_d;
        end
    end

    // BRAM strobes follow the handshake combinationally so the word lands in
    // the same cycle it is accepted.
    assign s_ready    = (state_q == S_LOAD);
    assign bram_en    = w_hs;
    assign bram_we    = w_hs;
    assign bram_addr  = w_hs ? addr_q : '0;
    assign bram_din   = w_hs ? s_data : '0;
    assign START      = start_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_ARM) || (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign error      = error_q;
    assign word_count = wc_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_program_loader
//  Description : Directed self-checking bench for ctrl_program_loader with a
//                small address space, short arm timeout and narrow counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_program_loader;

    localparam int AW = 3;
    localparam int CW = 60;
    localparam int NW = 4;
    localparam int TO = 16;

    logic          CLK_100   = 1'b0;
    logic          RST       = 1'b1;
    logic          cmd_load  = 1'b0;
    logic          cmd_run   = 1'b0;
    logic          cmd_clear = 1'b0;
    logic          s_valid   = 1'b0;
    logic          s_last    = 1'b0;
    logic          COMPLETED = 1'b1;
    logic [CW-1:0] s_data    = '0;
    logic          s_ready, bram_en, bram_we, START, busy, done;
    logic [AW-1:0] bram_addr;
    logic [CW-1:0] bram_din;
    logic [1:0]    error;
    logic [AW:0]   word_count;
    logic [NW-1:0] cycle_count;

    ctrl_program_loader #(
        .ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW), .ARM_TIMEOUT(TO)
    ) dut (
        .CLK_100(CLK_100), .RST(RST), .cmd_load(cmd_load), .cmd_run(cmd_run),
        .cmd_clear(cmd_clear), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_en(bram_en), .bram_we(bram_we),
        .START(START), .COMPLETED(COMPLETED), .busy(busy), .done(done),
        .error(error), .word_count(word_count), .cycle_count(cycle_count)
    );

    always #5 CLK_100 = ~CLK_100;

    int total = 0;
    int bad   = 0;

    // BRAM write log and START observation, sampled mid-cycle
    int            wr_cnt   = 0;
    int            start_cnt = 0;
    int            start_wr = 0;
    logic [AW-1:0] wr_a [0:31];
    logic [CW-1:0] wr_d [0:31];

    always @(negedge CLK_100) begin
        if (bram_en && bram_we) begin
            if (wr_cnt < 32) begin
                wr_a[wr_cnt] = bram_addr;
                wr_d[wr_cnt] = bram_din;
            end
            wr_cnt++;
            if (START) start_wr++;
        end
        if (START) start_cnt++;
    end

    task automatic tick();
        @(posedge CLK_100);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if ({s_ready, bram_en, bram_we, START, busy, done} !== 6'b0) begin bad++; $display("FAIL reset_flags got %b want 000000", {s_ready, bram_en, bram_we, START, busy, done}); end
        total++; if (error !== 2'b00) begin bad++; $display("FAIL reset_error got %b want 00", error); end
        total++; if (word_count !== '0) begin bad++; $display("FAIL reset_wc got %0d want 0", word_count); end
        total++; if (cycle_count !== '0) begin bad++; $display("FAIL reset_cc got %0d want 0", cycle_count); end
        total++; if ({bram_addr, bram_din} !== '0) begin bad++; $display("FAIL reset_bram got %0h/%0h want 0/0", bram_addr, bram_din); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_no_prog();
        int s0;
        s0 = start_cnt;
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        total++; if (error !== 2'b11) begin bad++; $display("FAIL noprog_error got %b want 11", error); end
        total++; if ({busy, done, START} !== 3'b000) begin bad++; $display("FAIL noprog_flags got %b want 000", {busy, done, START}); end
        tick(); tick(); tick();
        total++; if (start_cnt !== s0) begin bad++; $display("FAIL noprog_start got %0d want %0d", start_cnt, s0); end
        cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
        total++; if (error !== 2'b00) begin bad++; $display("FAIL noprog_clear got %b want 00", error); end
    endtask

    task automatic test_load_gapped();
        logic [CW-1:0] d [4];
        int base, s0;
        d[0] = 60'h123456789ABCDEF; d[1] = 60'hFEDCBA987654321;
        d[2] = 60'hA5A5A5A5A5A5A5A; d[3] = 60'h000000000000001;
        base = wr_cnt; s0 = start_cnt;
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        total++; if ({busy, s_ready} !== 2'b11) begin bad++; $display("FAIL load_enter got %b want 11", {busy, s_ready}); end
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b0; tick();
            s_data = d[i]; s_last = (i == 3); s_valid = 1'b1; #1;
            total++; if ({bram_en, bram_we, bram_addr} !== {2'b11, AW'(i)}) begin bad++; $display("FAIL load_strobe%0d got %b want %b", i, {bram_en, bram_we, bram_addr}, {2'b11, AW'(i)}); end
            tick(); s_valid = 1'b0; s_last = 1'b0;
        end
        tick();
        total++; if (wr_cnt - base !== 4) begin bad++; $display("FAIL load_nwrites got %0d want 4", wr_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({wr_a[base+i], wr_d[base+i]} !== {AW'(i), d[i]}) begin bad++; $display("FAIL load_word%0d got %0h/%0h want %0h/%0h", i, wr_a[base+i], wr_d[base+i], i, d[i]); end
        end
        total++; if (word_count !== 4'd4) begin bad++; $display("FAIL load_wc got %0d want 4", word_count); end
        total++; if ({busy, s_ready} !== 2'b00) begin bad++; $display("FAIL load_idle got %b want 00", {busy, s_ready}); end
        total++; if (start_cnt !== s0) begin bad++; $display("FAIL load_start got %0d want %0d", start_cnt, s0); end
    endtask

    task automatic test_run();
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        total++; if ({START, busy} !== 2'b11) begin bad++; $display("FAIL run_arm got %b want 11", {START, busy}); end
        tick(); tick();
        COMPLETED = 1'b0;
        repeat (10) tick();
        COMPLETED = 1'b1;
        tick();
        total++; if ({done, START, busy} !== 3'b110) begin bad++; $display("FAIL run_done got %b want 110", {done, START, busy}); end
        total++; if (cycle_count !== 4'd10) begin bad++; $display("FAIL run_cycles got %0d want 10", cycle_count); end
        tick();
        total++; if ({done, START} !== 2'b11) begin bad++; $display("FAIL run_hold got %b want 11", {done, START}); end
        cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
        total++; if ({done, START} !== 2'b00) begin bad++; $display("FAIL run_clear got %b want 00", {done, START}); end
        total++; if (cycle_count !== '0) begin bad++; $display("FAIL run_clear_cc got %0d want 0", cycle_count); end
        total++; if (word_count !== 4'd4) begin bad++; $display("FAIL run_keep_wc got %0d want 4", word_count); end
    endtask

    task automatic test_saturate();
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        COMPLETED = 1'b0;
        repeat (20) tick();
        total++; if ({busy, cycle_count} !== {1'b1, 4'd15}) begin bad++; $display("FAIL sat_run got %0d/%0d want 1/15", busy, cycle_count); end
        COMPLETED = 1'b1; tick();
        total++; if ({done, cycle_count} !== {1'b1, 4'd15}) begin bad++; $display("FAIL sat_done got %0d/%0d want 1/15", done, cycle_count); end
        cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    endtask

    task automatic test_arm_timeout();
        COMPLETED = 1'b1;
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        repeat (15) tick();
        total++; if ({busy, START, error} !== 4'b1100) begin bad++; $display("FAIL armto_early got %b want 1100", {busy, START, error}); end
        tick();
        total++; if ({busy, START, error} !== 4'b0010) begin bad++; $display("FAIL armto_err got %b want 0010", {busy, START, error}); end
        cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
        total++; if (error !== 2'b00) begin bad++; $display("FAIL armto_clear got %b want 00", error); end
    endtask

    task automatic test_overflow();
        int base;
        base = wr_cnt;
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s_data = CW'(256 + i);
            tick();
        end
        repeat (3) tick();
        total++; if (wr_cnt - base !== 8) begin bad++; $display("FAIL ovf_nwrites got %0d want 8", wr_cnt - base); end
        for (int i = 0; i < 8; i++) begin
            total++; if ({wr_a[base+i], wr_d[base+i]} !== {AW'(i), CW'(256 + i)}) begin bad++; $display("FAIL ovf_word%0d got %0h/%0h want %0h/%0h", i, wr_a[base+i], wr_d[base+i], i, 256 + i); end
        end
        total++; if ({error, s_ready} !== 3'b010) begin bad++; $display("FAIL ovf_err got %b want 010", {error, s_ready}); end
        total++; if (word_count !== 4'd8) begin bad++; $display("FAIL ovf_wc got %0d want 8", word_count); end
        s_valid = 1'b0;
        cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
        total++; if ({error, word_count} !== {2'b00, 4'd8}) begin bad++; $display("FAIL ovf_clear got %b/%0d want 00/8", error, word_count); end
    endtask

    task automatic test_full_load();
        int base;
        base = wr_cnt;
        cmd_load = 1'b1; cmd_run = 1'b1; tick(); cmd_load = 1'b0; cmd_run = 1'b0;
        total++; if ({s_ready, START} !== 2'b10) begin bad++; $display("FAIL full_prio got %b want 10", {s_ready, START}); end
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = CW'(512 + i); s_last = (i == 7);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        total++; if ({error, busy, word_count} !== {2'b00, 1'b0, 4'd8}) begin bad++; $display("FAIL full_end got %b/%b/%0d want 00/0/8", error, busy, word_count); end
        total++; if ({wr_cnt - base, wr_a[base+7]} !== {32'd8, AW'(7)}) begin bad++; $display("FAIL full_writes got %0d/%0d want 8/7", wr_cnt - base, wr_a[base+7]); end
    endtask

    task automatic test_clear_in_load();
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        s_valid = 1'b1; s_data = 60'h777; tick(); s_valid = 1'b0;
        cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
        total++; if ({busy, word_count} !== {1'b0, 4'd0}) begin bad++; $display("FAIL clrload got %b/%0d want 0/0", busy, word_count); end
    endtask

    task automatic test_reset_in_run();
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        s_valid = 1'b1; s_last = 1'b1; s_data = 60'h55; tick(); s_valid = 1'b0; s_last = 1'b0;
        total++; if (word_count !== 4'd1) begin bad++; $display("FAIL rstrun_wc got %0d want 1", word_count); end
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        COMPLETED = 1'b0;
        repeat (5) tick();
        total++; if ({START, cycle_count} !== {1'b1, 4'd5}) begin bad++; $display("FAIL rstrun_pre got %0d/%0d want 1/5", START, cycle_count); end
        #2 RST = 1'b1;
        #1;
        total++; if ({START, busy, cycle_count, word_count} !== '0) begin bad++; $display("FAIL rstrun_async got %b/%b/%0d/%0d want 0/0/0/0", START, busy, cycle_count, word_count); end
        tick(); tick();
        RST = 1'b0; COMPLETED = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_no_prog();
        test_load_gapped();
        test_run();
        test_saturate();
        test_arm_timeout();
        test_overflow();
        test_full_load();
        test_clear_in_load();
        test_reset_in_run();
        total++; if (start_wr !== 0) begin bad++; $display("FAIL start_during_write got %0d want 0", start_wr); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
